// File: rtl/dsa_system.sv
// Bilinear image downscaler with one shared word-addressed memory port.
// Source pixels are fetched tap by tap, blended in Q8.8 and written either
// one byte per write (sequential) or four packed pixels per word (SIMD).
module dsa_system #(
    parameter logic [15:0] ADDR_IN  = 16'd0,
    parameter logic [15:0] ADDR_OUT = 16'd16384,
    parameter int          FRAC     = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic        i_mode_select,
    input  logic        i_step_mode,
    input  logic        i_step_trig,
    input  logic [15:0] i_inv_scale,
    input  logic [8:0]  i_img_width,
    input  logic [8:0]  i_img_height,
    output logic        o_busy,
    output logic        o_done,
    output logic [15:0] o_mem_addr,
    output logic        o_mem_we,
    output logic [3:0]  o_mem_byte_en,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata
);

    localparam int RW  = FRAC + 9;
    localparam int SW  = 2 * FRAC + 9;
    localparam int ONE = 1 << FRAC;

    typedef enum logic [2:0] {
        IDLE, CALC_ADDR, PAUSED, READ, INTERP, WRITE, NEXT, DONE
    } state_t;

    state_t          state_q, state_d;
    logic            simdMode_q, simdMode_d;
    logic [15:0]     invScale_q, invScale_d;
    logic [8:0]      imgW_q, imgW_d;
    logic [8:0]      imgH_q, imgH_d;
    logic [19:0]     sxAcc_q, sxAcc_d;
    logic [19:0]     syAcc_q, syAcc_d;
    logic [17:0]     pixIdx_q, pixIdx_d;
    logic [8:0]      x0_q, x0_d, x1_q, x1_d, y0_q, y0_d, y1_q, y1_d;
    logic [FRAC-1:0] fx_q, fx_d, fy_q, fy_d;
    logic [1:0]      tap_q, tap_d;
    logic            phase_q, phase_d;
    logic [7:0]      taps_q [4];
    logic [7:0]      taps_d [4];
    logic [31:0]     wordBuf_q, wordBuf_d;
    logic [3:0]      laneEn_q, laneEn_d;
    logic            trigPrev_q;

    logic [19:0]     sxNext, syNext;
    logic            colWrap, lastPix, trigEdge;
    logic [8:0]      curX0, curX1, curY0, curY1;
    logic [FRAC-1:0] curFx, curFy;
    logic [8:0]      tapX, tapY;
    logic [17:0]     tapIdx;
    logic [7:0]      tapByte;
    logic [FRAC:0]   wx0, wy0;
    logic [RW-1:0]   r0, r1;
    logic [SW-1:0]   acc;
    logic [7:0]      pixVal;
    logic [1:0]      lane;

    assign sxNext   = sxAcc_q + 20'(invScale_q);
    assign syNext   = syAcc_q + 20'(invScale_q);
    assign colWrap  = (sxNext >> FRAC) >= 20'(imgW_q);
    assign lastPix  = colWrap && ((syNext >> FRAC) >= 20'(imgH_q));
    assign trigEdge = i_step_trig & ~trigPrev_q;

    assign curX0 = 9'(sxAcc_q >> FRAC);
    assign curY0 = 9'(syAcc_q >> FRAC);
    assign curFx = sxAcc_q[FRAC-1:0];
    assign curFy = syAcc_q[FRAC-1:0];
    assign curX1 = (10'(curX0) + 10'd1 < 10'(imgW_q)) ? curX0 + 9'd1 : imgW_q - 9'd1;
    assign curY1 = (10'(curY0) + 10'd1 < 10'(imgH_q)) ? curY0 + 9'd1 : imgH_q - 9'd1;

    assign tapX    = tap_q[0] ? x1_q : x0_q;
    assign tapY    = tap_q[1] ? y1_q : y0_q;
    assign tapIdx  = 18'(tapY) * 18'(imgW_q) + 18'(tapX);
    assign tapByte = i_mem_rdata[{tapIdx[1:0], 3'b000} +: 8];

    assign wx0    = (FRAC+1)'(ONE) - (FRAC+1)'(fx_q);
    assign wy0    = (FRAC+1)'(ONE) - (FRAC+1)'(fy_q);
    assign r0     = RW'(taps_q[0]) * RW'(wx0) + RW'(taps_q[1]) * RW'(fx_q);
    assign r1     = RW'(taps_q[2]) * RW'(wx0) + RW'(taps_q[3]) * RW'(fx_q);
    assign acc    = SW'(r0) * SW'(wy0) + SW'(r1) * SW'(fy_q) + SW'(1 << (2 * FRAC - 1));
    assign pixVal = acc[2*FRAC +: 8];
    assign lane   = pixIdx_q[1:0];

    assign o_busy = (state_q != IDLE) && (state_q != DONE);
    assign o_done = (state_q == DONE);

    // Memory port: tap address held through both READ cycles, write strobe
    // only in WRITE and suppressed while reset is asserted.
    always_comb begin
        o_mem_addr    = '0;
        o_mem_we      = 1'b0;
        o_mem_byte_en = '0;
        o_mem_wdata   = '0;
        case (state_q)
            READ: begin
                o_mem_addr = ADDR_IN + 16'(tapIdx >> 2);
            end
            WRITE: begin
                o_mem_addr    = ADDR_OUT + 16'(pixIdx_q >> 2);
                o_mem_we      = ~rst;
                o_mem_byte_en = rst ? 4'b0000 : laneEn_q;
                o_mem_wdata   = wordBuf_q;
            end
            default: ;
        endcase
    end

    // Next-state logic: walk the output grid by stepping the source
    // accumulators, fetch four taps, blend, and pack into the write word.
    always_comb begin
        state_d    = state_q;
        simdMode_d = simdMode_q;
        invScale_d = invScale_q;
        imgW_d     = imgW_q;
        imgH_d     = imgH_q;
        sxAcc_d    = sxAcc_q;
        syAcc_d    = syAcc_q;
        pixIdx_d   = pixIdx_q;
        x0_d       = x0_q;
        x1_d       = x1_q;
        y0_d       = y0_q;
        y1_d       = y1_q;
        fx_d       = fx_q;
        fy_d       = fy_q;
        tap_d      = tap_q;
        phase_d    = phase_q;
        taps_d     = taps_q;
        wordBuf_d  = wordBuf_q;
        laneEn_d   = laneEn_q;
        case (state_q)
            IDLE, DONE: begin
                if (i_start) begin
                    simdMode_d = i_mode_select;
                    invScale_d = (i_inv_scale == 16'd0) ? 16'h0100 : i_inv_scale;
                    imgW_d     = i_img_width;
                    imgH_d     = i_img_height;
                    sxAcc_d    = '0;
                    syAcc_d    = '0;
                    pixIdx_d   = '0;
                    wordBuf_d  = '0;
                    laneEn_d   = '0;
                    state_d    = CALC_ADDR;
                end
            end
            CALC_ADDR: begin
                x0_d    = curX0;
                x1_d    = curX1;
                y0_d    = curY0;
                y1_d    = curY1;
                fx_d    = curFx;
                fy_d    = curFy;
                tap_d   = 2'd0;
                phase_d = 1'b0;
                if (i_step_mode && (!simdMode_q || lane == 2'd0)) begin
                    state_d = PAUSED;
                end else begin
                    state_d = READ;
                end
            end
            PAUSED: begin
                if (!i_step_mode || trigEdge) begin
                    state_d = READ;
                end
            end
            READ: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    taps_d[tap_q] = tapByte;
                    phase_d       = 1'b0;
                    tap_d         = tap_q + 2'd1;
                    if (tap_q == 2'd3) begin
                        state_d = INTERP;
                    end
                end
            end
            INTERP: begin
                wordBuf_d[{lane, 3'b000} +: 8] = pixVal;
                laneEn_d[lane]                 = 1'b1;
                if (!simdMode_q || lane == 2'd3 || lastPix) begin
                    state_d = WRITE;
                end else begin
                    state_d = NEXT;
                end
            end
            WRITE: begin
                wordBuf_d = '0;
                laneEn_d  = '0;
                state_d   = NEXT;
            end
            NEXT: begin
                if (lastPix) begin
                    state_d = DONE;
                end else begin
                    pixIdx_d = pixIdx_q + 18'd1;
                    if (colWrap) begin
                        sxAcc_d = '0;
                        syAcc_d = syNext;
                    end else begin
                        sxAcc_d = sxNext;
                    end
                    state_d = CALC_ADDR;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset; the step-trigger
    // history is sampled every cycle so a held button yields a single edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            simdMode_q <= 1'b0;
            invScale_q <= '0;
            imgW_q     <= '0;
            imgH_q     <= '0;
            sxAcc_q    <= '0;
            syAcc_q    <= '0;
            pixIdx_q   <= '0;
            x0_q       <= '0;
            x1_q       <= '0;
            y0_q       <= '0;
            y1_q       <= '0;
            fx_q       <= '0;
            fy_q       <= '0;
            tap_q      <= '0;
            phase_q    <= 1'b0;
            taps_q     <= '{default: '0};
            wordBuf_q  <= '0;
            laneEn_q   <= '0;
            trigPrev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            simdMode_q <= simdMode_d;
            invScale_q <= invScale_d;
            imgW_q     <= imgW_d;
            imgH_q     <= imgH_d;
            sxAcc_q    <= sxAcc_d;
            syAcc_q    <= syAcc_d;
            pixIdx_q   <= pixIdx_d;
            x0_q       <= x0_d;
            x1_q       <= x1_d;
            y0_q       <= y0_d;
            y1_q       <= y1_d;
            fx_q       <= fx_d;
            fy_q       <= fy_d;
            tap_q      <= tap_d;
            phase_q    <= phase_d;
            taps_q     <= taps_d;
            wordBuf_q  <= wordBuf_d;
            laneEn_q   <= laneEn_d;
            trigPrev_q <= i_step_trig;
        end
    end

endmodule

// File: tb/tb_dsa_system.sv
// Bench for the bilinear downscaler: a synchronous-read memory model feeds the
// DUT, expected writes are queued at job launch and a monitor pops them.
module tb_dsa_system;

    typedef struct {
        logic [15:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } wr_t;

    logic        clk;
    logic        rst;
    logic        i_start;
    logic        i_mode_select;
    logic        i_step_mode;
    logic        i_step_trig;
    logic [15:0] i_inv_scale;
    logic [8:0]  i_img_width;
    logic [8:0]  i_img_height;
    logic        o_busy;
    logic        o_done;
    logic [15:0] o_mem_addr;
    logic        o_mem_we;
    logic [3:0]  o_mem_byte_en;
    logic [31:0] o_mem_wdata;
    logic [31:0] i_mem_rdata;

    logic [31:0] srcMem [0:16383];
    logic [7:0]  srcPix [0:65535];
    wr_t         expQ[$];
    wr_t         writeLog[$];
    int          checks = 0;
    int          failures = 0;
    int          expWrites = 0;

    dsa_system dut (
        .clk(clk),
        .rst(rst),
        .i_start(i_start),
        .i_mode_select(i_mode_select),
        .i_step_mode(i_step_mode),
        .i_step_trig(i_step_trig),
        .i_inv_scale(i_inv_scale),
        .i_img_width(i_img_width),
        .i_img_height(i_img_height),
        .o_busy(o_busy),
        .o_done(o_done),
        .o_mem_addr(o_mem_addr),
        .o_mem_we(o_mem_we),
        .o_mem_byte_en(o_mem_byte_en),
        .o_mem_wdata(o_mem_wdata),
        .i_mem_rdata(i_mem_rdata)
    );

    // Free-running 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read memory: data for an address appears after one edge
    // and is sampled by the DUT on the following edge
    always @(posedge clk) begin
        i_mem_rdata <= srcMem[o_mem_addr[13:0]];
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Monitor: every write strobe seen mid-cycle is logged and checked
    // against the head of the expected-write queue
    always @(negedge clk) begin
        wr_t got;
        wr_t exp;
        if (o_mem_we === 1'b1) begin
            got.addr = o_mem_addr;
            got.be   = o_mem_byte_en;
            got.data = o_mem_wdata;
            writeLog.push_back(got);
            checkOutput("wr_pending", 32'(expQ.size() != 0), 32'd1);
            if (expQ.size() != 0) begin
                exp = expQ.pop_front();
                checkOutput("wr_addr", 32'(got.addr), 32'(exp.addr));
                checkOutput("wr_be", 32'(got.be), 32'(exp.be));
                checkOutput("wr_data", got.data, exp.data);
            end
        end
    end

    function automatic logic [7:0] refPixel(input int w, input int h, input int inv, input int ox, input int oy);
        int sx, sy, x0, x1, y0, y1, fx, fy, r0, r1, v;
        sx = ox * inv;
        sy = oy * inv;
        x0 = sx / 256;
        fx = sx % 256;
        y0 = sy / 256;
        fy = sy % 256;
        x1 = (x0 + 1 < w) ? x0 + 1 : w - 1;
        y1 = (y0 + 1 < h) ? y0 + 1 : h - 1;
        r0 = srcPix[y0*w+x0] * (256 - fx) + srcPix[y0*w+x1] * fx;
        r1 = srcPix[y1*w+x0] * (256 - fx) + srcPix[y1*w+x1] * fx;
        v  = (r0 * (256 - fy) + r1 * fy + 32768) >> 16;
        return v[7:0];
    endfunction

    task automatic pushExpected(input bit simd, input int w, input int h, input int invIn);
        int  inv;
        int  ow;
        int  oh;
        int  total;
        wr_t e;
        inv = (invIn == 0) ? 256 : invIn;
        ow = 0;
        oh = 0;
        while (((ow * inv) >> 8) < w) ow++;
        while (((oh * inv) >> 8) < h) oh++;
        total = ow * oh;
        expWrites = 0;
        if (!simd) begin
            for (int k = 0; k < total; k++) begin
                e.addr = 16'(16384 + k / 4);
                e.be   = 4'(1 << (k % 4));
                e.data = 32'(refPixel(w, h, inv, k % ow, k / ow)) << (8 * (k % 4));
                expQ.push_back(e);
                expWrites++;
            end
        end else begin
            for (int g = 0; g < total; g += 4) begin
                e.addr = 16'(16384 + g / 4);
                e.be   = '0;
                e.data = '0;
                for (int n = 0; n < 4; n++) begin
                    if (g + n < total) begin
                        e.be[n] = 1'b1;
                        e.data  = e.data | (32'(refPixel(w, h, inv, (g + n) % ow, (g + n) / ow)) << (8 * n));
                    end
                end
                expQ.push_back(e);
                expWrites++;
            end
        end
    endtask

    task automatic loadImage(input int w, input int h, input bit ramp);
        logic [7:0] v;
        for (int idx = 0; idx < w * h; idx++) begin
            if (ramp) v = 8'(32 + 8 * (idx / w) + (idx % w));
            else      v = 8'(8'h11 * (idx + 1));
            srcPix[idx] = v;
            srcMem[idx / 4][(idx % 4) * 8 +: 8] = v;
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit simd, input int w, input int h, input logic [15:0] inv);
        writeLog.delete();
        pushExpected(simd, w, h, int'(inv));
        @(posedge clk);
        #1;
        i_mode_select = simd;
        i_inv_scale   = inv;
        i_img_width   = 9'(w);
        i_img_height  = 9'(h);
        i_start       = 1'b1;
        waitCycles(1);
        i_start = 1'b0;
    endtask

    task automatic waitDone(input string name, input int budget);
        for (int c = 0; c < budget; c++) begin
            if (o_done === 1'b1) break;
            waitCycles(1);
        end
        checkOutput({name, "_done"}, 32'(o_done), 32'd1);
        checkOutput({name, "_idle"}, 32'(o_busy), 32'd0);
        checkOutput({name, "_count"}, 32'(writeLog.size()), 32'(expWrites));
        checkOutput({name, "_drained"}, 32'(expQ.size()), 32'd0);
    endtask

    // Watchdog so the bench can never hang
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios
    initial begin
        rst = 1'b1;
        i_start = 1'b0;
        i_mode_select = 1'b0;
        i_step_mode = 1'b0;
        i_step_trig = 1'b0;
        i_inv_scale = '0;
        i_img_width = '0;
        i_img_height = '0;
        for (int i = 0; i < 16384; i++) srcMem[i] = '0;
        waitCycles(2);
        rst = 1'b0;
        checkOutput("rst_busy", 32'(o_busy), 32'd0);
        checkOutput("rst_done", 32'(o_done), 32'd0);
        checkOutput("rst_we", 32'(o_mem_we), 32'd0);
        checkOutput("rst_be", 32'(o_mem_byte_en), 32'd0);
        checkOutput("rst_addr", 32'(o_mem_addr), 32'd0);
        checkOutput("rst_wdata", o_mem_wdata, 32'd0);

        $display("[TB] SIMD 8x4 ramp, inv 0x155");
        loadImage(8, 4, 1'b1);
        applyStimulus(1'b1, 8, 4, 16'h0155);
        checkOutput("start_busy", 32'(o_busy), 32'd1);
        waitCycles(20);
        i_start = 1'b1;
        waitCycles(1);
        i_start = 1'b0;
        waitDone("simd", 3000);
        checkOutput("simd_log_size", 32'(writeLog.size()), 32'd7);
        if (writeLog.size() >= 7) begin
            checkOutput("simd_first_addr", 32'(writeLog[0].addr), 32'd16384);
            checkOutput("simd_first_data", writeLog[0].data, 32'h24232120);
            checkOutput("simd_first_be", 32'(writeLog[0].be), 32'hF);
            checkOutput("simd_last_addr", 32'(writeLog[6].addr), 32'd16390);
            checkOutput("simd_last_be", 32'(writeLog[6].be), 32'hF);
            checkOutput("edge_clamp_pix", 32'(writeLog[6].data[31:24]), 32'h3F);
        end

        $display("[TB] sequential 8x4 ramp");
        applyStimulus(1'b0, 8, 4, 16'h0155);
        checkOutput("restart_clears_done", 32'(o_done), 32'd0);
        waitDone("seq", 6000);
        if (writeLog.size() >= 4) begin
            checkOutput("seq_w0_be", 32'(writeLog[0].be), 32'h1);
            checkOutput("seq_w1_be", 32'(writeLog[1].be), 32'h2);
            checkOutput("seq_w2_be", 32'(writeLog[2].be), 32'h4);
            checkOutput("seq_w3_be", 32'(writeLog[3].be), 32'h8);
            checkOutput("seq_w0_data", writeLog[0].data, 32'h00000020);
            checkOutput("seq_w1_data", writeLog[1].data, 32'h00002100);
            checkOutput("seq_w2_data", writeLog[2].data, 32'h00230000);
            checkOutput("seq_w3_data", writeLog[3].data, 32'h24000000);
            checkOutput("seq_w3_addr", 32'(writeLog[3].addr), 32'd16384);
        end
        waitCycles(5);
        checkOutput("done_held", 32'(o_done), 32'd1);

        $display("[TB] step mode sequential");
        i_step_mode = 1'b1;
        applyStimulus(1'b0, 8, 4, 16'h0155);
        waitCycles(50);
        checkOutput("step_no_traffic", 32'(writeLog.size()), 32'd0);
        checkOutput("step_busy", 32'(o_busy), 32'd1);
        for (int i = 0; i < 3; i++) begin
            i_step_trig = 1'b1;
            waitCycles(3);
            i_step_trig = 1'b0;
            waitCycles(40);
            checkOutput("step_one_write", 32'(writeLog.size()), 32'(i + 1));
        end
        i_step_mode = 1'b0;
        waitDone("step", 6000);

        $display("[TB] identity 4x2, inv 0x100 and 0");
        loadImage(4, 2, 1'b0);
        applyStimulus(1'b1, 4, 2, 16'h0100);
        waitDone("ident", 2000);
        if (writeLog.size() >= 2) begin
            checkOutput("ident_w0", writeLog[0].data, 32'h44332211);
            checkOutput("ident_w1", writeLog[1].data, 32'h88776655);
        end
        applyStimulus(1'b1, 4, 2, 16'h0000);
        waitDone("inv0", 2000);
        if (writeLog.size() >= 2) begin
            checkOutput("inv0_w0", writeLog[0].data, 32'h44332211);
            checkOutput("inv0_w1", writeLog[1].data, 32'h88776655);
        end

        $display("[TB] reset mid-run then rerun");
        loadImage(8, 4, 1'b1);
        applyStimulus(1'b1, 8, 4, 16'h0155);
        waitCycles(60);
        rst = 1'b1;
        waitCycles(1);
        rst = 1'b0;
        checkOutput("abort_busy", 32'(o_busy), 32'd0);
        checkOutput("abort_done", 32'(o_done), 32'd0);
        checkOutput("abort_we", 32'(o_mem_we), 32'd0);
        expQ.delete();
        writeLog.delete();
        waitCycles(30);
        checkOutput("abort_no_stale", 32'(writeLog.size()), 32'd0);
        applyStimulus(1'b1, 8, 4, 16'h0155);
        waitDone("rerun", 3000);
        if (writeLog.size() >= 1) begin
            checkOutput("rerun_first_data", writeLog[0].data, 32'h24232120);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
